// File: rtl/layer_batch_sequencer_pkg.sv
// Shared definitions for the layer/batch run sequencer: state encoding and width helpers.
package layer_batch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_CLEAR     = 3'd2,
        ST_START     = 3'd3,
        ST_RUN       = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_DONE      = 3'd6
    } seq_state_e;

    localparam int STATE_W = 3;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_batch_sequencer_load_tracker.sv
// Sticky weight/ifmap load-complete flags; a done pulse wins over a same-cycle clear
// so a load that was prefetched during a layer change is not lost.
module seq_load_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic weight_done,
    input  logic ifmap_done,
    input  logic clear,
    output logic data_load_ready
);

    logic w_flag_r;
    logic i_flag_r;
    logic w_next_s;
    logic i_next_s;

    // Next flag values: set has priority over clear.
    always_comb begin
        w_next_s = weight_done | (w_flag_r & ~clear);
        i_next_s = ifmap_done  | (i_flag_r & ~clear);
    end

    // Flag and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_flag_r        <= 1'b0;
            i_flag_r        <= 1'b0;
            data_load_ready <= 1'b0;
        end else begin
            w_flag_r        <= w_next_s;
            i_flag_r        <= i_next_s;
            data_load_ready <= w_next_s & i_next_s;
        end
    end

endmodule

// File: rtl/layer_batch_sequencer.sv
// Run controller: waits for loads, then walks every batch of every layer through
// clear -> schedule -> compute -> stream drain.
module layer_batch_sequencer
    import layer_batch_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS        = 4,
    parameter int BATCHES_PER_LAYER = 8,
    parameter int LAYER_W           = 2,
    parameter int BATCH_W           = 3,
    parameter int CLEAR_CYCLES      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               weight_write_done,
    input  logic               ifmap_write_done,
    input  logic               ext_scheduler_start,
    input  logic               sched_batch_complete,
    input  logic               out_stream_done,
    output logic               sched_start,
    output logic [BATCH_W-1:0] current_batch_id,
    output logic [LAYER_W-1:0] current_layer_id,
    output logic               layer_transition,
    output logic               clear_output_bram,
    output logic               out_stream_start,
    output logic               all_batches_complete,
    output logic               data_load_ready,
    output logic               auto_start_active,
    output logic               protocol_error,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int                 CLR_W      = id_width(CLEAR_CYCLES);
    localparam logic [CLR_W-1:0]   CLR_LOAD   = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [CLR_W-1:0]   CLR_ZERO   = CLR_W'(0);
    localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(BATCHES_PER_LAYER - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    seq_state_e         state_r;
    seq_state_e         next_state_s;
    logic [CLR_W-1:0]   clr_cnt_r;
    logic [BATCH_W-1:0] batch_r;
    logic [LAYER_W-1:0] layer_r;

    logic drain_done_s;
    logic batch_more_s;
    logic layer_more_s;
    logic layer_adv_s;
    logic restart_s;
    logic flag_clear_s;
    logic proto_err_s;
    logic ready_s;

    logic clear_d_s;
    logic sched_start_d_s;
    logic out_stream_start_d_s;
    logic all_done_d_s;
    logic auto_active_d_s;

    assign drain_done_s = (state_r == ST_DRAIN) && out_stream_done;
    assign batch_more_s = (batch_r < LAST_BATCH);
    assign layer_more_s = (layer_r < LAST_LAYER);
    assign layer_adv_s  = drain_done_s && !batch_more_s && layer_more_s;
    assign restart_s    = (state_r == ST_DONE) && ext_scheduler_start;
    assign flag_clear_s = layer_adv_s || restart_s;
    assign proto_err_s  = (out_stream_done && (state_r != ST_DRAIN)) ||
                          (sched_batch_complete && (state_r != ST_RUN));

    seq_load_tracker u_load_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .weight_done     (weight_write_done),
        .ifmap_done      (ifmap_write_done),
        .clear           (flag_clear_s),
        .data_load_ready (ready_s)
    );

    assign data_load_ready  = ready_s;
    assign state_dbg        = state_r;
    assign current_batch_id = batch_r;
    assign current_layer_id = layer_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_WAIT_LOAD: begin
                if (ready_s || ext_scheduler_start) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == CLR_ZERO) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_START: next_state_s = ST_RUN;
            ST_RUN: begin
                if (sched_batch_complete) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!out_stream_done) begin
                    next_state_s = ST_DRAIN;
                end else if (batch_more_s) begin
                    next_state_s = ST_CLEAR;
                end else if (layer_more_s) begin
                    next_state_s = ST_WAIT_LOAD;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ext_scheduler_start) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output can be registered.
    always_comb begin
        clear_d_s            = 1'b0;
        sched_start_d_s      = 1'b0;
        all_done_d_s         = 1'b0;
        auto_active_d_s      = 1'b0;
        out_stream_start_d_s = (state_r == ST_RUN) && sched_batch_complete;
        case (next_state_s)
            ST_CLEAR: begin
                clear_d_s       = 1'b1;
                auto_active_d_s = 1'b1;
            end
            ST_START: begin
                sched_start_d_s = 1'b1;
                auto_active_d_s = 1'b1;
            end
            ST_RUN, ST_DRAIN, ST_WAIT_LOAD: auto_active_d_s = 1'b1;
            ST_DONE:                        all_done_d_s    = 1'b1;
            default:                        auto_active_d_s = 1'b0;
        endcase
    end

    // Registered outputs, clear down-counter and layer/batch counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_output_bram    <= 1'b0;
            sched_start          <= 1'b0;
            out_stream_start     <= 1'b0;
            layer_transition     <= 1'b0;
            all_batches_complete <= 1'b0;
            auto_start_active    <= 1'b0;
            protocol_error       <= 1'b0;
            clr_cnt_r            <= CLR_ZERO;
            batch_r              <= BATCH_W'(0);
            layer_r              <= LAYER_W'(0);
        end else begin
            clear_output_bram    <= clear_d_s;
            sched_start          <= sched_start_d_s;
            out_stream_start     <= out_stream_start_d_s;
            layer_transition     <= layer_adv_s;
            all_batches_complete <= all_done_d_s;
            auto_start_active    <= auto_active_d_s;
            protocol_error       <= protocol_error | proto_err_s;

            if ((next_state_s == ST_CLEAR) && (state_r != ST_CLEAR)) begin
                clr_cnt_r <= CLR_LOAD;
            end else if ((state_r == ST_CLEAR) && (clr_cnt_r != CLR_ZERO)) begin
                clr_cnt_r <= clr_cnt_r - CLR_W'(1);
            end else begin
                clr_cnt_r <= clr_cnt_r;
            end

            // Counters saturate on the final batch; only a restart from DONE rewinds them.
            if (restart_s) begin
                batch_r <= BATCH_W'(0);
                layer_r <= LAYER_W'(0);
            end else if (drain_done_s && batch_more_s) begin
                batch_r <= batch_r + BATCH_W'(1);
            end else if (layer_adv_s) begin
                batch_r <= BATCH_W'(0);
                layer_r <= layer_r + LAYER_W'(1);
            end else begin
                batch_r <= batch_r;
                layer_r <= layer_r;
            end
        end
    end

endmodule

// File: tb/tb_layer_batch_sequencer.sv
// Directed bench for layer_batch_sequencer with 2 layers x 2 batches and a 4-cycle clear.
module tb_layer_batch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       weight_write_done = 1'b0;
    logic       ifmap_write_done = 1'b0;
    logic       ext_scheduler_start = 1'b0;
    logic       sched_batch_complete = 1'b0;
    logic       out_stream_done = 1'b0;
    logic       sched_start;
    logic [0:0] current_batch_id;
    logic [0:0] current_layer_id;
    logic       layer_transition;
    logic       clear_output_bram;
    logic       out_stream_start;
    logic       all_batches_complete;
    logic       data_load_ready;
    logic       auto_start_active;
    logic       protocol_error;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;
    int ss_cnt = 0;
    int os_cnt = 0;
    int lt_cnt = 0;

    layer_batch_sequencer #(
        .NUM_LAYERS(2), .BATCHES_PER_LAYER(2), .LAYER_W(1), .BATCH_W(1), .CLEAR_CYCLES(4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .weight_write_done    (weight_write_done),
        .ifmap_write_done     (ifmap_write_done),
        .ext_scheduler_start  (ext_scheduler_start),
        .sched_batch_complete (sched_batch_complete),
        .out_stream_done      (out_stream_done),
        .sched_start          (sched_start),
        .current_batch_id     (current_batch_id),
        .current_layer_id     (current_layer_id),
        .layer_transition     (layer_transition),
        .clear_output_bram    (clear_output_bram),
        .out_stream_start     (out_stream_start),
        .all_batches_complete (all_batches_complete),
        .data_load_ready      (data_load_ready),
        .auto_start_active    (auto_start_active),
        .protocol_error       (protocol_error),
        .state_dbg            (state_dbg)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (sched_start)      ss_cnt <= ss_cnt + 1;
        if (out_stream_start) os_cnt <= os_cnt + 1;
        if (layer_transition) lt_cnt <= lt_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({sched_start, current_batch_id, current_layer_id, layer_transition,
                    clear_output_bram, out_stream_start, all_batches_complete,
                    data_load_ready, auto_start_active, protocol_error, state_dbg});
    endfunction

    // Wait (bounded) for a sched_start pulse and check the ids it carries.
    task automatic wait_ss(input int lay, input int bat);
        int n = 0;
        while (sched_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("sched_start_seen", 32'(sched_start), 32'd1);
        chk("start_state", 32'(state_dbg), 32'd3);
        chk("start_layer", 32'(current_layer_id), 32'(lay));
        chk("start_batch", 32'(current_batch_id), 32'(bat));
    endtask

    // Compute for 20 cycles, then drain for 10; optionally prefetch weights with the drain.
    task automatic finish_batch(input bit with_weight);
        repeat (20) step();
        sched_batch_complete = 1'b1;
        step();
        sched_batch_complete = 1'b0;
        chk("drain_state", 32'(state_dbg), 32'd5);
        chk("os_start_pulse", 32'(out_stream_start), 32'd1);
        step();
        chk("os_start_one_cycle", 32'(out_stream_start), 32'd0);
        repeat (8) step();
        out_stream_done   = 1'b1;
        weight_write_done = with_weight;
        step();
        out_stream_done   = 1'b0;
        weight_write_done = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        step();

        // Load handshake timing.
        weight_write_done = 1'b1;
        step();
        weight_write_done = 1'b0;
        chk("ready_after_weight_only", 32'(data_load_ready), 32'd0);
        repeat (4) step();
        ifmap_write_done = 1'b1;
        step();
        ifmap_write_done = 1'b0;
        chk("ready_set", 32'(data_load_ready), 32'd1);
        chk("idle_before_clear", 32'(state_dbg), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("clear_high", 32'({clear_output_bram, sched_start}), 32'd2);
        end
        step();
        chk("clear_low_start_high", 32'({clear_output_bram, sched_start}), 32'd1);

        // Full run.
        wait_ss(0, 0);
        finish_batch(1'b0);
        chk("next_batch_clear", 32'({state_dbg, current_batch_id}), 32'({3'd2, 1'b1}));
        wait_ss(0, 1);
        finish_batch(1'b0);
        chk("wait_load_state", 32'(state_dbg), 32'd1);
        chk("layer_transition", 32'(layer_transition), 32'd1);
        chk("layer_ids", 32'({current_layer_id, current_batch_id}), 32'({1'b1, 1'b0}));
        chk("flags_cleared", 32'(data_load_ready), 32'd0);
        step();
        chk("layer_transition_one_cycle", 32'(layer_transition), 32'd0);
        repeat (4) step();
        weight_write_done = 1'b1;
        step();
        weight_write_done = 1'b0;
        chk("still_waiting_ifmap", 32'({state_dbg, data_load_ready}), 32'({3'd1, 1'b0}));
        ifmap_write_done = 1'b1;
        step();
        ifmap_write_done = 1'b0;
        chk("ready_layer1", 32'(data_load_ready), 32'd1);
        wait_ss(1, 0);
        finish_batch(1'b0);
        wait_ss(1, 1);
        finish_batch(1'b0);
        chk("done_state", 32'(state_dbg), 32'd6);
        chk("all_complete", 32'({all_batches_complete, auto_start_active}), 32'd2);
        chk("ss_count", 32'(ss_cnt), 32'd4);
        chk("os_count", 32'(os_cnt), 32'd4);
        chk("lt_count", 32'(lt_cnt), 32'd1);
        chk("no_protocol_error", 32'(protocol_error), 32'd0);
        repeat (3) step();
        chk("done_terminal", 32'({state_dbg, all_batches_complete}), 32'({3'd6, 1'b1}));

        // Restart from DONE.
        ext_scheduler_start = 1'b1;
        step();
        ext_scheduler_start = 1'b0;
        chk("restart_state", 32'(state_dbg), 32'd0);
        chk("restart_clears", 32'({all_batches_complete, current_layer_id, current_batch_id,
                                   data_load_ready}), 32'd0);

        // Second run: protocol error, ignored restart, prefetched weights.
        weight_write_done = 1'b1;
        ifmap_write_done  = 1'b1;
        step();
        weight_write_done = 1'b0;
        ifmap_write_done  = 1'b0;
        chk("run2_ready", 32'(data_load_ready), 32'd1);
        wait_ss(0, 0);
        step();
        out_stream_done = 1'b1;
        step();
        out_stream_done = 1'b0;
        chk("osd_in_run_err", 32'({protocol_error, state_dbg}), 32'({1'b1, 3'd4}));
        ext_scheduler_start = 1'b1;
        step();
        ext_scheduler_start = 1'b0;
        chk("ext_in_run_ignored", 32'({state_dbg, current_batch_id}), 32'({3'd4, 1'b0}));
        finish_batch(1'b0);
        wait_ss(0, 1);
        finish_batch(1'b1);
        chk("prefetch_wait_load", 32'({state_dbg, layer_transition, data_load_ready}),
            32'({3'd1, 1'b1, 1'b0}));
        repeat (3) step();
        ifmap_write_done = 1'b1;
        step();
        ifmap_write_done = 1'b0;
        chk("prefetch_kept_ready", 32'(data_load_ready), 32'd1);
        wait_ss(1, 0);
        repeat (20) step();
        sched_batch_complete = 1'b1;
        step();
        sched_batch_complete = 1'b0;
        step();
        chk("pre_reset_drain", 32'({state_dbg, auto_start_active}), 32'({3'd5, 1'b1}));

        // Asynchronous reset mid-drain.
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_reset_idle", all_outs(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
